// File: rtl/adc_frame_align.sv
// Frame alignment and lock monitor for the LVDS ADC receive path.
// Bitslips the deserialisers until the FCLK word matches the frame pattern, then watches for lock loss.
module adc_frame_align #(
    parameter int unsigned AdcBits       = 14,
    parameter int unsigned AdcLanes      = 4,
    parameter int unsigned AdcFrmPattern = 16256,
    parameter int unsigned SettleCycles  = 4,
    parameter int unsigned MatchCount    = 8,
    parameter int unsigned LossThresh    = 4,
    parameter int unsigned MaxRounds     = 2,
    localparam int unsigned SlipW        = $clog2(AdcBits * MaxRounds + 1)
) (
    input  logic                         FrmClk,
    input  logic                         FrmRst_n,
    input  logic                         FrmEna,
    input  logic                         FrmReSync,
    input  logic [AdcBits-1:0]           FrmWord,
    input  logic [AdcLanes*AdcBits-1:0]  DatIn,
    output logic                         FrmBitslip,
    output logic                         FrmAlignDone,
    output logic                         FrmAlignFail,
    output logic                         FrmLockLost,
    output logic [SlipW-1:0]             SlipCount,
    output logic [7:0]                   RelockCount,
    output logic [AdcLanes*AdcBits-1:0]  DatOut,
    output logic [AdcLanes-1:0]          DatValid
);

    localparam int unsigned SettleW = $clog2(SettleCycles + 1);
    localparam int unsigned MatchW  = $clog2(MatchCount + 1);
    localparam int unsigned LossW   = $clog2(LossThresh + 1);

    localparam logic [AdcBits-1:0] Pattern    = AdcBits'(AdcFrmPattern);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
    localparam logic [MatchW-1:0]  MatchLast  = MatchW'(MatchCount - 1);
    localparam logic [LossW-1:0]   LossLast   = LossW'(LossThresh - 1);
    localparam logic [SlipW-1:0]   SlipBudget = SlipW'(AdcBits * MaxRounds);

    typedef enum logic [2:0] {
        StIdle, StSettle, StCheck, StSlip, StLocked, StFail
    } state_e;

    state_e                        state_q, state_d;
    logic [SettleW-1:0]            settle_q;
    logic [MatchW-1:0]             match_q;
    logic [LossW-1:0]              loss_q;
    logic [SlipW-1:0]              slip_q;
    logic [7:0]                    relock_q;
    logic                          bitslip_q, done_q, fail_q, lost_q;
    logic [AdcLanes*AdcBits-1:0]   dat_q;
    logic [AdcLanes-1:0]           valid_q;

    logic match, clr, lose;

    assign match = (FrmWord == Pattern);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        lose    = 1'b0;
        if (!FrmEna) begin
            state_d = StIdle;
            clr     = 1'b1;
        end else if (FrmReSync && state_q != StIdle) begin
            // Resync beats a coincident loss-of-lock: no pulse, no relock count.
            state_d = StSettle;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSettle;
                    clr     = 1'b1;
                end
                StSettle: if (settle_q == SettleLast) state_d = StCheck;
                StCheck: begin
                    if (!match)                  state_d = StSlip;
                    else if (match_q == MatchLast) state_d = StLocked;
                end
                StSlip:   state_d = (slip_q == SlipBudget) ? StFail : StSettle;
                StLocked: begin
                    if (!match && loss_q == LossLast) begin
                        state_d = StSettle;
                        lose    = 1'b1;
                    end
                end
                StFail:   state_d = StFail;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge FrmClk or negedge FrmRst_n) begin
        if (!FrmRst_n) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            match_q   <= '0;
            loss_q    <= '0;
            slip_q    <= '0;
            relock_q  <= '0;
            bitslip_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            lost_q    <= 1'b0;
            dat_q     <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            bitslip_q <= (state_d == StSlip);
            done_q    <= (state_d == StLocked);
            fail_q    <= (state_d == StFail);
            valid_q   <= {AdcLanes{state_d == StLocked}};
            lost_q    <= lose;
            dat_q     <= DatIn;

            settle_q <= (!clr && state_q == StSettle && state_d == StSettle) ?
                        settle_q + 1'b1 : '0;
            match_q  <= (!clr && state_q == StCheck && match) ? match_q + 1'b1 : '0;
            loss_q   <= (!clr && !lose && state_q == StLocked && !match) ? loss_q + 1'b1 : '0;

            if (clr || lose)            slip_q <= '0;
            else if (state_d == StSlip) slip_q <= slip_q + 1'b1;

            if (lose && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
        end
    end

    assign FrmBitslip   = bitslip_q;
    assign FrmAlignDone = done_q;
    assign FrmAlignFail = fail_q;
    assign FrmLockLost  = lost_q;
    assign SlipCount    = slip_q;
    assign RelockCount  = relock_q;
    assign DatOut       = dat_q;
    assign DatValid     = valid_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align: lock, bitslip search, fail, loss/relock, reset and datapath.
module tb_adc_frame_align;

    localparam logic [13:0] Pat = 14'h3F80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, resync;
    logic [13:0] frm_word, word_drv;
    logic [55:0] dat_in;
    logic        bitslip, done, fail, lost;
    logic [4:0]  slip_cnt;
    logic [7:0]  relock;
    logic [55:0] dat_out;
    logic [3:0]  dat_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses, last_slip, min_gap, mis;
    logic model_en;

    typedef struct {
        logic [13:0] word;
        logic        done;
        logic        lost;
        logic [7:0]  relock;
    } vec_t;
    vec_t vecs[9];

    adc_frame_align dut (
        .FrmClk      (clk),
        .FrmRst_n    (rst_n),
        .FrmEna      (ena),
        .FrmReSync   (resync),
        .FrmWord     (frm_word),
        .DatIn       (dat_in),
        .FrmBitslip  (bitslip),
        .FrmAlignDone(done),
        .FrmAlignFail(fail),
        .FrmLockLost (lost),
        .SlipCount   (slip_cnt),
        .RelockCount (relock),
        .DatOut      (dat_out),
        .DatValid    (dat_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] rotl(input logic [13:0] v, input int n);
        logic [13:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[12:0], r[13]};
        return r;
    endfunction

    // Deserialiser model: each bitslip removes one position of misalignment.
    assign frm_word = model_en ? rotl(Pat, mis) : word_drv;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bitslip) begin
            pulses++;
            if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
            last_slip = cyc;
            if (model_en && mis > 0) mis--;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] ramp(input int i);
        logic [55:0] v;
        for (int l = 0; l < 4; l++) v[l*14 +: 14] = 14'(i * 4 + l + 14'h100);
        return v;
    endfunction

    task automatic clr_mon();
        pulses    = 0;
        last_slip = -1;
        min_gap   = 1000;
    endtask

    initial begin
        vecs[0] = '{14'h0000, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{14'h1234, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{14'h3F81, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{Pat,      1'b1, 1'b0, 8'd0};
        vecs[4] = '{14'h0000, 1'b1, 1'b0, 8'd0};
        vecs[5] = '{14'h1FC0, 1'b1, 1'b0, 8'd0};
        vecs[6] = '{14'h3F00, 1'b1, 1'b0, 8'd0};
        vecs[7] = '{14'h0001, 1'b0, 1'b1, 8'd1};
        vecs[8] = '{Pat,      1'b0, 1'b0, 8'd1};

        rst_n = 1'b0; ena = 1'b0; resync = 1'b0;
        word_drv = 14'h0; model_en = 1'b0; mis = 0; dat_in = '0;
        clr_mon();
        #23;
        chk("rst_bitslip", bitslip, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_lost", lost, 0);
        chk("rst_slipcnt", slip_cnt, 0);
        chk("rst_relock", relock, 0);
        chk("rst_datout", dat_out, 0);
        chk("rst_valid", dat_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Already aligned: lock without slipping.
        word_drv = Pat;
        step();
        ena = 1'b1;
        for (int i = 0; i < 14 && !done; i++) step();
        chk("t1_done", done, 1);
        chk("t1_no_slip", pulses, 0);
        chk("t1_slipcnt", slip_cnt, 0);

        // Datapath while locked.
        for (int i = 0; i < 6; i++) begin
            dat_in = ramp(i);
            step();
            chk("t6_datout", dat_out, ramp(i));
            chk("t6_valid_on", dat_valid, 4'hF);
        end

        // Loss-of-lock table: 3 bad, good, 4 bad, good.
        for (int i = 0; i < 9; i++) begin
            word_drv = vecs[i].word;
            step();
            chk($sformatf("t4_done[%0d]", i), done, vecs[i].done);
            chk($sformatf("t4_lost[%0d]", i), lost, vecs[i].lost);
            chk($sformatf("t4_relock[%0d]", i), relock, vecs[i].relock);
            chk($sformatf("t4_valid[%0d]", i), dat_valid, {4{vecs[i].done}});
        end
        for (int i = 0; i < 20 && !done; i++) step();
        chk("t4_relocked", done, 1);
        chk("t4_no_slip", pulses, 0);

        // Disable while locked.
        ena = 1'b0;
        dat_in = ramp(40);
        step();
        chk("t5_ena_done", done, 0);
        chk("t5_ena_valid", dat_valid, 0);
        chk("t5_ena_datout", dat_out, ramp(40));
        step();

        // Rotated by 5: five slips spaced >= 6 cycles, then lock.
        clr_mon();
        model_en = 1'b1;
        mis = 5;
        ena = 1'b1;
        for (int i = 0; i < 200 && !done; i++) step();
        chk("t2_done", done, 1);
        chk("t2_pulses", pulses, 5);
        chk("t2_gap", min_gap >= 6, 1);
        chk("t2_slipcnt", slip_cnt, 5);

        // Never matching: budget of 28 slips then sticky fail.
        ena = 1'b0;
        step();
        model_en = 1'b0;
        word_drv = 14'h0;
        clr_mon();
        ena = 1'b1;
        for (int i = 0; i < 400 && !fail; i++) step();
        chk("t3_fail", fail, 1);
        chk("t3_pulses", pulses, 28);
        chk("t3_slipcnt", slip_cnt, 28);
        chk("t3_gap", min_gap >= 6, 1);
        for (int i = 0; i < 30; i++) step();
        chk("t3_no_more_slip", pulses, 28);
        chk("t3_fail_sticky", fail, 1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("t3_resync_cnt", slip_cnt, 0);
        chk("t3_resync_fail", fail, 0);
        for (int i = 0; i < 20 && !bitslip; i++) step();
        chk("t3_resume_slip", bitslip, 1);

        // Async reset in the middle of a slip.
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bitslip", bitslip, 0);
        chk("t5_rst_slipcnt", slip_cnt, 0);
        chk("t5_rst_relock", relock, 0);
        chk("t5_rst_datout", dat_out, 0);
        chk("t5_rst_fail", fail, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
